// File: rtl/mantissa_divider.sv
// Restoring divider for normalized mantissas: {1,in0} / {1,in1}, one quotient bit per cycle,
// normalized into [1,2) with the pre-shift reported on borrow, rounded to nearest even.
module mantissa_divider #(
    parameter int BIT_WIDTH = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] in0,
    input  logic [BIT_WIDTH-1:0] in1,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] out,
    output logic                 borrow
);

    localparam int RW = BIT_WIDTH + 2;
    localparam int CW = $clog2(BIT_WIDTH + 3);
    localparam logic [CW-1:0] ITER_COUNT = CW'(BIT_WIDTH + 2);
    localparam logic [CW-1:0] LAST_ITER  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ITER  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic rne_round_up(input logic g, input logic r, input logic s,
                                          input logic lsb);
        return g & (r | s | lsb);
    endfunction

    state_t               state_q, state_d;
    logic [BIT_WIDTH:0]   a_q, a_d;
    logic [BIT_WIDTH:0]   b_q, b_d;
    logic [RW-1:0]        rem_q, rem_d;
    logic [RW-1:0]        quo_q, quo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 borrow_pend_q, borrow_pend_d;
    logic [BIT_WIDTH-1:0] out_q, out_d;
    logic                 borrow_q, borrow_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [RW-1:0]        a_ext_s;
    logic [RW-1:0]        a_dbl_s;
    logic [RW-1:0]        b_ext_s;
    logic [RW-1:0]        rem_shift_s;
    logic                 round_up_s;

    // R < B < 2^(BIT_WIDTH+1), so doubling R never loses its top bit.
    assign a_ext_s     = {1'b0, a_q};
    assign a_dbl_s     = {a_q, 1'b0};
    assign b_ext_s     = {1'b0, b_q};
    assign rem_shift_s = {rem_q[RW-2:0], 1'b0};
    assign round_up_s  = rne_round_up(quo_q[1], quo_q[0], |rem_q, quo_q[2]);

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        cnt_d         = cnt_q;
        borrow_pend_d = borrow_pend_q;
        out_d         = out_q;
        borrow_d      = borrow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = {1'b1, in0};
                    b_d     = {1'b1, in1};
                    state_d = S_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                if (a_ext_s >= b_ext_s) begin
                    borrow_pend_d = 1'b0;
                    rem_d         = a_ext_s - b_ext_s;
                end else begin
                    borrow_pend_d = 1'b1;
                    rem_d         = a_dbl_s - b_ext_s;
                end
                quo_d   = {RW{1'b0}};
                cnt_d   = ITER_COUNT;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (rem_shift_s >= b_ext_s) begin
                    rem_d = rem_shift_s - b_ext_s;
                    quo_d = {quo_q[RW-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift_s;
                    quo_d = {quo_q[RW-2:0], 1'b0};
                end
                cnt_d = cnt_q - LAST_ITER;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_ROUND;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ROUND: begin
                // quo_q holds {fraction, G, R}; the quotient bound keeps the increment in range.
                out_d    = quo_q[RW-1:2] + BIT_WIDTH'(round_up_s);
                borrow_d = borrow_pend_q;
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_INIT) || (state_d == S_ITER) || (state_d == S_ROUND);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            a_q           <= {(BIT_WIDTH+1){1'b0}};
            b_q           <= {(BIT_WIDTH+1){1'b0}};
            rem_q         <= {RW{1'b0}};
            quo_q         <= {RW{1'b0}};
            cnt_q         <= {CW{1'b0}};
            borrow_pend_q <= 1'b0;
            out_q         <= {BIT_WIDTH{1'b0}};
            borrow_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            cnt_q         <= cnt_d;
            borrow_pend_q <= borrow_pend_d;
            out_q         <= out_d;
            borrow_q      <= borrow_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign out    = out_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_mantissa_divider.sv
// Scoreboard bench for mantissa_divider: directed cases, start-while-busy, mid-run reset,
// and randomized back-to-back divides against an exact-quotient RNE reference.
module tb_mantissa_divider;

    localparam int W   = 23;
    localparam int LAT = W + 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         borrow;

    always #5 clk = ~clk;

    mantissa_divider #(.BIT_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in0    (in0),
        .in1    (in1),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .borrow (borrow)
    );

    typedef struct {
        logic [W-1:0] out;
        logic         borrow;
        int           acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Exact quotient of the normalized mantissas, rounded to nearest even on the remainder.
    task automatic model(input logic [W-1:0] a0, input logic [W-1:0] b0,
                         output logic [W-1:0] o, output logic br, output logic no_carry);
        longint unsigned a, b, num, q, rem;
        a   = 64'(a0) | (64'd1 << W);
        b   = 64'(b0) | (64'd1 << W);
        br  = (a < b);
        num = br ? (a << 1) : a;
        q   = (num << W) / b;
        rem = (num << W) % b;
        if ((2 * rem > b) || ((2 * rem == b) && ((q & 64'd1) == 64'd1)))
            q = q + 64'd1;
        no_carry = (q < (64'd1 << (W + 1)));
        o = W'(q);
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
        in0   = a;
        in1   = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in0   = W'($urandom);
        in1   = W'($urandom);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] o;
        logic         br, nc;
        wait_not_busy();
        pulse_start(a, b);
        model(a, b, o, br, nc);
        check("no_carry", {63'd0, nc}, 64'd1);
        sb_q.push_back('{o, br, cyc});
    endtask

    task automatic issue_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] o, input logic br);
        wait_not_busy();
        pulse_start(a, b);
        sb_q.push_back('{o, br, cyc});
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || sb_q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", sb_q.size());
        end
    endtask

    // Monitor: every done must match the oldest pending result and its start-to-done latency.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with out=0x%0h, required no done", out);
            end else begin
                e = sb_q.pop_front();
                check("out", 64'(out), 64'(e.out));
                check("borrow", 64'(borrow), 64'(e.borrow));
                check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
            end
        end
    end

    initial begin
        logic [W-1:0] a, b;
        rst   = 1'b1;
        start = 1'b0;
        in0   = '0;
        in1   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        check("rst_borrow", 64'(borrow), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1.0 / 1.0 with busy/done observed cycle by cycle
        issue_exp(23'h000000, 23'h000000, 23'h000000, 1'b0);
        for (int i = 0; i < LAT; i++) begin
            check("run_busy", 64'(busy), 64'd1);
            check("run_done", 64'(done), 64'd0);
            @(posedge clk); #1;
        end
        check("done_busy", 64'(busy), 64'd0);
        check("done_pulse", 64'(done), 64'd1);

        issue_exp(23'h400000, 23'h000000, 23'h400000, 1'b0);
        issue_exp(23'h000000, 23'h400000, 23'h2AAAAB, 1'b1);
        issue_exp(23'h000000, 23'h7FFFFF, 23'h000001, 1'b1);
        issue_exp(23'h7FFFFF, 23'h000000, 23'h7FFFFF, 1'b0);
        issue_exp(23'h2AAAAA, 23'h2AAAAA, 23'h000000, 1'b0);
        drain();

        // Start while busy must be ignored
        issue_exp(23'h400000, 23'h000000, 23'h400000, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        pulse_start(23'h123456, 23'h654321);
        drain();
        repeat (40) begin @(posedge clk); #1; end

        // Reset in the middle of a run aborts it and clears the outputs
        wait_not_busy();
        pulse_start(23'h2AAAAA, 23'h111111);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_out", 64'(out), 64'd0);
        check("abort_borrow", 64'(borrow), 64'd0);
        repeat (40) begin @(posedge clk); #1; end

        // Randomized back-to-back divides, biased toward the boundary cases
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = a;
                2:       a = '1;
                3:       b = '1;
                default: ;
            endcase
            issue(a, b);
        end
        drain();
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
